soc_axi_mem_bridge: RTL and testbench
=====================================

# soc_axi_mem_bridge

AXI4 slave to single-port synchronous RAM bridge. Sits directly downstream of the SoC AXI4 retime stage and consumes its outport channels, turning AW/W/B and AR/R bursts into word accesses on one on-chip RAM port. Reads and writes share the RAM port, with round-robin arbitration between them. A small read-return buffer absorbs RREADY backpressure, so the bridge sustains one beat per cycle in both directions.

## Interface
Parameters:
- RAM_ADDR_W, 14, RAM word-address width; the RAM holds 2^RAM_ADDR_W 32-bit words.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-low (0 = reset).
- axi_awvalid_i / axi_awready_o  in / out  1  write-address handshake.
- axi_awaddr_i  in  32  byte address.
- axi_awid_i  in  4  write ID.
- axi_awlen_i  in  8  beats - 1.
- axi_awburst_i  in  2  burst type.
- axi_wvalid_i / axi_wready_o  in / out  1  write-data handshake.
- axi_wdata_i  in  32  write data.
- axi_wstrb_i  in  4  byte strobes.
- axi_wlast_i  in  1  last beat; ignored.
- axi_bvalid_o / axi_bready_i  out / in  1  write-response handshake.
- axi_bresp_o  out  2  write response; always 2'b00.
- axi_bid_o  out  4  write response ID.
- axi_arvalid_i / axi_arready_o  in / out  1  read-address handshake.
- axi_araddr_i  in  32  byte address.
- axi_arid_i  in  4  read ID.
- axi_arlen_i  in  8  beats - 1.
- axi_arburst_i  in  2  burst type.
- axi_rvalid_o / axi_rready_i  out / in  1  read-data handshake.
- axi_rdata_o  out  32  read data.
- axi_rresp_o  out  2  read response; always 2'b00.
- axi_rid_o  out  4  read ID.
- axi_rlast_o  out  1  last read beat.
- ram_addr_o  out  RAM_ADDR_W  word address = byte address [RAM_ADDR_W+1:2].
- ram_wr_o  out  4  per-byte write enables.
- ram_rd_o  out  1  read enable.
- ram_wdata_o  out  32  write data.
- ram_rdata_i  in  32  read data; valid the cycle after ram_rd_o.

## Operation
- States: IDLE, WRITE, WRESP, READ.
- IDLE arbitration:
  - If only awvalid or only arvalid is high, grant that channel.
  - If both are high, grant the channel not granted last. The last-grant flag resets to "read", so a write wins the first tie.
  - The grant asserts awready_o or arready_o combinationally for that one cycle only.
  - The handshake captures addr, id, len and burst, loads the beat counter with len, and moves to WRITE or READ.
- WRITE:
  - wready_o = 1.
  - Each wvalid beat drives ram_wr_o = wstrb, ram_wdata_o = wdata and ram_addr_o = current address, then advances the address.
  - The beat with counter = 0 ends the burst and moves to WRESP. wlast is not checked.
- WRESP:
  - bvalid_o = 1 with bid = captured ID.
  - The bready handshake returns to IDLE.
- READ:
  - Issues one ram_rd_o per cycle while (buffer count + in-flight - pop this cycle) < 2.
  - Returning ram_rdata_i is pushed into a 2-entry FIFO together with rid and the rlast flag; rlast is set for beat counter = 0 at issue time.
  - After the last beat is issued, the state stays in READ until the FIFO is empty and nothing is in flight, then returns to IDLE.
- Address generation, in 32-bit byte arithmetic, 4 bytes per beat:
  - FIXED (00): address held.
  - INCR (01), and reserved 11: address + 4, wraps modulo 2^32.
  - WRAP (10): mask = {len, 2'b11}; next = (addr & ~mask) | ((addr + 4) & mask). Valid for len 1, 3, 7, 15.
- Addresses above the RAM size alias; there is no error response.
- Outputs after reset:
  - all ready and valid signals 0, ram_wr_o = 0, ram_rd_o = 0;
  - bresp, rresp, bid, rid, rdata and rlast = 0;
  - state IDLE, FIFO empty.
- Reset asserted mid-burst abandons the burst immediately; no partial response is produced.

## Timing
- AW/AR accept: same cycle as valid when the bridge is in IDLE and the channel wins arbitration.
- First W beat can be accepted the cycle after the AW handshake.
- bvalid_o is high the cycle after the last W beat.
- Read latency: AR handshake in cycle N, ram_rd_o in N+1, data in the FIFO at the end of N+2, rvalid_o in N+3.
- With rready held high, a (len+1)-beat read has one beat per cycle and no bubbles.
- RREADY low: at most 2 reads outstanding. The FIFO never overflows and data order is preserved.
- The next command is accepted no earlier than the cycle after the bridge returns to IDLE.
- The RAM port carries only one access type per cycle.

## Configuration
- SOC_AXI_MEM_WRAP_EN defined: WRAP bursts follow the wrap formula above.
- Not defined: WRAP (10) is treated as INCR and the mask logic is removed.

## Test plan
- Single write, then read: AW addr 0x10, len 0, wdata 0xDEADBEEF, strb 0xF, then AR 0x10 -> bresp 00, ram_addr 4, rdata 0xDEADBEEF, rlast 1.
- INCR read, 4 beats, rready high: AR 0x100, len 3, id 5 -> rvalid_o on 4 consecutive cycles starting 3 cycles after the AR handshake, rid 5, rlast on beat 4 only.
- WRAP read with macro on: AR 0x38, len 3 -> word addresses 0x0E, 0x0F, 0x0C, 0x0D. With the macro off -> 0x0E, 0x0F, 0x10, 0x11.
- Backpressure: 8-beat read with rready toggling 1 0 0 1 -> no beat lost or duplicated, ram_rd_o never has more than 2 outstanding, data in order.
- Simultaneous awvalid and arvalid out of reset -> write granted first, the read next. A second tie -> read wins.
- Byte strobes, then reset mid-burst: strb 0x5 -> ram_wr_o = 0x5. Holding rst_i low during beat 2 of 4 -> all outputs return to reset values on the next clock, and the bridge accepts a new AW after release.

Source files
------------

// File: rtl/soc_axi_mem_bridge.sv
// soc_axi_mem_bridge: AXI4 slave bursts onto one single-port synchronous RAM.
// Define SOC_AXI_MEM_WRAP_EN for WRAP addressing; otherwise WRAP acts as INCR.
module soc_axi_mem_bridge #(
  parameter int RAM_ADDR_W = 14
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  axi_awvalid_i,
  output logic                  axi_awready_o,
  input  logic [31:0]           axi_awaddr_i,
  input  logic [3:0]            axi_awid_i,
  input  logic [7:0]            axi_awlen_i,
  input  logic [1:0]            axi_awburst_i,
  input  logic                  axi_wvalid_i,
  output logic                  axi_wready_o,
  input  logic [31:0]           axi_wdata_i,
  input  logic [3:0]            axi_wstrb_i,
  input  logic                  axi_wlast_i,
  output logic                  axi_bvalid_o,
  input  logic                  axi_bready_i,
  output logic [1:0]            axi_bresp_o,
  output logic [3:0]            axi_bid_o,
  input  logic                  axi_arvalid_i,
  output logic                  axi_arready_o,
  input  logic [31:0]           axi_araddr_i,
  input  logic [3:0]            axi_arid_i,
  input  logic [7:0]            axi_arlen_i,
  input  logic [1:0]            axi_arburst_i,
  output logic                  axi_rvalid_o,
  input  logic                  axi_rready_i,
  output logic [31:0]           axi_rdata_o,
  output logic [1:0]            axi_rresp_o,
  output logic [3:0]            axi_rid_o,
  output logic                  axi_rlast_o,
  output logic [RAM_ADDR_W-1:0] ram_addr_o,
  output logic [3:0]            ram_wr_o,
  output logic                  ram_rd_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, addr_nxt;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  id_q;
  logic [1:0]  burst_q;
  logic        last_wr_q;
  logic        done_q, done_d;
  logic        infl_q, infl_last_q;
  logic [31:0] fdata_q [2];
  logic [3:0]  fid_q [2];
  logic [1:0]  flast_q;
  logic        wp_q, rp_q;
  logic [1:0]  fcnt_q;
  logic        grant_w, grant_r, issue, pop;
  logic [2:0]  occ;
  logic        unused_wlast;

  assign unused_wlast = axi_wlast_i;

`ifdef SOC_AXI_MEM_WRAP_EN
  logic [7:0]  len_q;
  logic [31:0] wmask;
  assign wmask = {22'd0, len_q, 2'b11};
`endif

  always_comb begin
    addr_nxt = addr_q + 32'd4;
    if (burst_q == 2'b00)
      addr_nxt = addr_q;
`ifdef SOC_AXI_MEM_WRAP_EN
    else if (burst_q == 2'b10)
      addr_nxt = (addr_q & ~wmask)
               | ((addr_q + 32'd4) & wmask);
`endif
  end

  assign grant_w = (state_q == IDLE) && axi_awvalid_i
                && (!axi_arvalid_i || !last_wr_q);
  assign grant_r = (state_q == IDLE) && axi_arvalid_i
                && !grant_w;

  // Issue only while buffered + in-flight beats leave room in the FIFO.
  assign pop   = (fcnt_q != 2'd0) && axi_rready_i;
  assign occ   = {1'b0, fcnt_q} + {2'b00, infl_q}
               - {2'b00, pop};
  assign issue = (state_q == READ) && !done_q && (occ < 3'd2);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    done_d        = done_q;
    axi_awready_o = grant_w;
    axi_arready_o = grant_r;
    axi_wready_o  = 1'b0;
    axi_bvalid_o  = 1'b0;
    ram_wr_o      = 4'd0;
    ram_rd_o      = issue;
    ram_wdata_o   = 32'd0;
    unique case (state_q)
      IDLE: begin
        if (grant_w) begin
          state_d = WRITE;
          addr_d  = axi_awaddr_i;
          cnt_d   = axi_awlen_i;
        end else if (grant_r) begin
          state_d = READ;
          addr_d  = axi_araddr_i;
          cnt_d   = axi_arlen_i;
          done_d  = 1'b0;
        end
      end
      WRITE: begin
        axi_wready_o = 1'b1;
        if (axi_wvalid_i) begin
          ram_wr_o    = axi_wstrb_i;
          ram_wdata_o = axi_wdata_i;
          addr_d      = addr_nxt;
          cnt_d       = cnt_q - 8'd1;
          if (cnt_q == 8'd0)
            state_d = WRESP;
        end
      end
      WRESP: begin
        axi_bvalid_o = 1'b1;
        if (axi_bready_i)
          state_d = IDLE;
      end
      READ: begin
        if (issue) begin
          addr_d = addr_nxt;
          cnt_d  = cnt_q - 8'd1;
          if (cnt_q == 8'd0)
            done_d = 1'b1;
        end
        if (done_q && fcnt_q == 2'd0 && !infl_q)
          state_d = IDLE;
      end
    endcase
  end

  assign ram_addr_o   = addr_q[RAM_ADDR_W+1:2];
  assign axi_bresp_o  = 2'b00;
  assign axi_rresp_o  = 2'b00;
  assign axi_bid_o    = (state_q == WRESP) ? id_q : 4'd0;
  assign axi_rvalid_o = (fcnt_q != 2'd0);
  assign axi_rdata_o  = axi_rvalid_o ? fdata_q[rp_q] : 32'd0;
  assign axi_rid_o    = axi_rvalid_o ? fid_q[rp_q] : 4'd0;
  assign axi_rlast_o  = axi_rvalid_o && flast_q[rp_q];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      addr_q      <= 32'd0;
      cnt_q       <= 8'd0;
      id_q        <= 4'd0;
      burst_q     <= 2'b00;
      last_wr_q   <= 1'b0;
      done_q      <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      fdata_q[0]  <= 32'd0;
      fdata_q[1]  <= 32'd0;
      fid_q[0]    <= 4'd0;
      fid_q[1]    <= 4'd0;
      flast_q     <= 2'b00;
      wp_q        <= 1'b0;
      rp_q        <= 1'b0;
      fcnt_q      <= 2'd0;
`ifdef SOC_AXI_MEM_WRAP_EN
      len_q       <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (grant_w || grant_r) begin
        id_q      <= grant_w ? axi_awid_i : axi_arid_i;
        burst_q   <= grant_w ? axi_awburst_i : axi_arburst_i;
        last_wr_q <= grant_w;
`ifdef SOC_AXI_MEM_WRAP_EN
        len_q     <= grant_w ? axi_awlen_i : axi_arlen_i;
`endif
      end
      infl_q      <= issue;
      infl_last_q <= (cnt_q == 8'd0);
      if (infl_q) begin
        fdata_q[wp_q] <= ram_rdata_i;
        fid_q[wp_q]   <= id_q;
        flast_q[wp_q] <= infl_last_q;
        wp_q          <= ~wp_q;
      end
      if (pop)
        rp_q <= ~rp_q;
      fcnt_q <= fcnt_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_soc_axi_mem_bridge.sv
// tb_soc_axi_mem_bridge: random AXI bursts against a word-level memory model.
// Expectations are queued at issue; a negedge monitor pops and compares.
module tb_soc_axi_mem_bridge;
  localparam int AW = 14;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  id;
    logic        last;
  } rexp_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [3:0]    s;
    logic [31:0]   d;
  } wexp_t;

  logic clk_i = 1'b0;
  logic rst_i;
  logic axi_awvalid_i, axi_awready_o;
  logic [31:0] axi_awaddr_i;
  logic [3:0] axi_awid_i;
  logic [7:0] axi_awlen_i;
  logic [1:0] axi_awburst_i;
  logic axi_wvalid_i, axi_wready_o;
  logic [31:0] axi_wdata_i;
  logic [3:0] axi_wstrb_i;
  logic axi_wlast_i;
  logic axi_bvalid_o, axi_bready_i;
  logic [1:0] axi_bresp_o;
  logic [3:0] axi_bid_o;
  logic axi_arvalid_i, axi_arready_o;
  logic [31:0] axi_araddr_i;
  logic [3:0] axi_arid_i;
  logic [7:0] axi_arlen_i;
  logic [1:0] axi_arburst_i;
  logic axi_rvalid_o, axi_rready_i;
  logic [31:0] axi_rdata_o;
  logic [1:0] axi_rresp_o;
  logic [3:0] axi_rid_o;
  logic axi_rlast_o;
  logic [AW-1:0] ram_addr_o;
  logic [3:0] ram_wr_o;
  logic ram_rd_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i = 32'd0;

  always #5 clk_i = ~clk_i;

  soc_axi_mem_bridge #(.RAM_ADDR_W(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
    .axi_awaddr_i(axi_awaddr_i), .axi_awid_i(axi_awid_i),
    .axi_awlen_i(axi_awlen_i), .axi_awburst_i(axi_awburst_i),
    .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
    .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i),
    .axi_wlast_i(axi_wlast_i),
    .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i),
    .axi_bresp_o(axi_bresp_o), .axi_bid_o(axi_bid_o),
    .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
    .axi_araddr_i(axi_araddr_i), .axi_arid_i(axi_arid_i),
    .axi_arlen_i(axi_arlen_i), .axi_arburst_i(axi_arburst_i),
    .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i),
    .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
    .axi_rid_o(axi_rid_o), .axi_rlast_o(axi_rlast_o),
    .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o),
    .ram_rd_o(ram_rd_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i)
  );

  int n_chk = 0, n_pass = 0, cyc = 0;
  int ar_cyc = 0, prev_cyc = 0, iss = 0, pops = 0;
  int rmode = 0;
  bit first_pending = 0, in_burst = 0, clr = 1;

  rexp_t exp_r[$];
  wexp_t exp_w[$];
  wexp_t wdrv[$];
  logic [AW-1:0] exp_ra[$];
  logic [3:0] exp_b[$];

  logic [31:0] ram [0:(1<<AW)-1];
  logic [31:0] mdl [0:(1<<AW)-1];
  logic [63:0] outv;

  assign outv = {9'd0, axi_awready_o, axi_wready_o, axi_bvalid_o,
                 axi_bresp_o, axi_bid_o, axi_arready_o, axi_rvalid_o,
                 axi_rdata_o, axi_rresp_o, axi_rid_o, axi_rlast_o,
                 ram_wr_o, ram_rd_o};

  function automatic logic [31:0] merge(input logic [31:0] o,
      input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [AW-1:0] widx(input logic [31:0] a);
    return a[AW+1:2];
  endfunction

  // Next byte address from the burst rules, as plain arithmetic.
  function automatic logic [31:0] nxt(input logic [31:0] a,
      input logic [7:0] len, input logic [1:0] bt);
    logic [31:0] bytes, base;
    bytes = (32'(len) + 32'd1) * 32'd4;
    base = (a / bytes) * bytes;
    if (bt == 2'b00) return a;
`ifdef SOC_AXI_MEM_WRAP_EN
    if (bt == 2'b10) return base + ((a + 32'd4 - base) % bytes);
`endif
    return a + 32'd4;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
      input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s act=%0h req=%0h t=%0t", nm, act, req, $time);
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i) begin
    if (clr) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= 32'd0;
    end else begin
      if (ram_rd_o) ram_rdata_i <= ram[ram_addr_o];
      if (ram_wr_o != 4'd0)
        ram[ram_addr_o] <= merge(ram[ram_addr_o], ram_wdata_o, ram_wr_o);
    end
  end

  initial begin
    logic [3:0] pat;
    int pidx;
    pat = 4'b1001;
    pidx = 0;
    axi_rready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (rmode == 0) axi_rready_i = 1'b1;
      else if (rmode == 1) axi_rready_i = 1'($urandom_range(0, 1));
      else begin
        axi_rready_i = pat[3 - (pidx % 4)];
        pidx++;
      end
    end
  end

  always @(negedge clk_i) begin
    wexp_t we;
    rexp_t re;
    logic [AW-1:0] ra;
    if (rst_i) begin
      if (ram_wr_o != 4'd0) begin
        if (exp_w.size() == 0) chk("ram_wr_unexpected", ram_wr_o, 0);
        else begin
          we = exp_w.pop_front();
          chk("ram_wr_addr", ram_addr_o, we.a);
          chk("ram_wr_strb", ram_wr_o, we.s);
          chk("ram_wdata", ram_wdata_o, we.d);
        end
      end
      if (ram_rd_o) begin
        iss++;
        chk("ram_one_type", ram_wr_o, 0);
        if (exp_ra.size() == 0) chk("ram_rd_unexpected", ram_rd_o, 0);
        else begin
          ra = exp_ra.pop_front();
          chk("ram_rd_addr", ram_addr_o, ra);
        end
      end
      if (first_pending && axi_rvalid_o) begin
        chk("r_latency", 64'(cyc), 64'(ar_cyc + 3));
        first_pending = 0;
      end
      if (axi_rvalid_o && axi_rready_i) begin
        pops++;
        if (exp_r.size() == 0) chk("r_unexpected", axi_rvalid_o, 0);
        else begin
          re = exp_r.pop_front();
          chk("rdata", axi_rdata_o, re.d);
          chk("rid", axi_rid_o, re.id);
          chk("rlast", axi_rlast_o, re.last);
          chk("rresp", axi_rresp_o, 0);
          if (rmode == 0 && in_burst)
            chk("r_nobubble", 64'(cyc), 64'(prev_cyc + 1));
          prev_cyc = cyc;
          in_burst = !re.last;
        end
      end
      if (ram_rd_o) begin
        n_chk++;
        if (iss - pops <= 2) n_pass++;
        else $display("FAIL rd_outstanding act=%0d req<=2", iss - pops);
      end
      if (axi_bvalid_o && axi_bready_i) begin
        if (exp_b.size() == 0) chk("b_unexpected", axi_bvalid_o, 0);
        else begin
          chk("bid", axi_bid_o, exp_b.pop_front());
          chk("bresp", axi_bresp_o, 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic plan_write(input logic [31:0] a0, input logic [3:0] id,
      input logic [7:0] len, input logic [1:0] bt, input bit fx,
      input logic [31:0] fd, input logic [3:0] fs);
    wexp_t e;
    logic [31:0] a;
    a = a0;
    for (int i = 0; i <= int'(len); i++) begin
      e.a = widx(a);
      e.d = fx ? fd : $urandom;
      e.s = fx ? fs : 4'($urandom_range(1, 15));
      wdrv.push_back(e);
      exp_w.push_back(e);
      mdl[e.a] = merge(mdl[e.a], e.d, e.s);
      a = nxt(a, len, bt);
    end
    exp_b.push_back(id);
  endtask

  task automatic plan_read(input logic [31:0] a0, input logic [3:0] id,
      input logic [7:0] len, input logic [1:0] bt);
    rexp_t e;
    logic [31:0] a;
    a = a0;
    for (int i = 0; i <= int'(len); i++) begin
      exp_ra.push_back(widx(a));
      e.d = mdl[widx(a)];
      e.id = id;
      e.last = (i == int'(len));
      exp_r.push_back(e);
      a = nxt(a, len, bt);
    end
  endtask

  task automatic hs_aw(input logic [31:0] a, input logic [3:0] id,
      input logic [7:0] len, input logic [1:0] bt);
    bit ok;
    int n;
    axi_awaddr_i = a; axi_awid_i = id;
    axi_awlen_i = len; axi_awburst_i = bt;
    axi_awvalid_i = 1'b1;
    ok = 0; n = 0;
    while (!ok && n < 200) begin
      @(negedge clk_i);
      ok = axi_awready_o;
      n++;
    end
    if (!ok) chk("aw_timeout", 0, 1);
    tick();
    axi_awvalid_i = 1'b0;
  endtask

  task automatic hs_ar(input logic [31:0] a, input logic [3:0] id,
      input logic [7:0] len, input logic [1:0] bt);
    bit ok;
    int n;
    axi_araddr_i = a; axi_arid_i = id;
    axi_arlen_i = len; axi_arburst_i = bt;
    axi_arvalid_i = 1'b1;
    ok = 0; n = 0;
    while (!ok && n < 200) begin
      @(negedge clk_i);
      ok = axi_arready_o;
      n++;
    end
    if (!ok) chk("ar_timeout", 0, 1);
    else begin
      ar_cyc = cyc;
      first_pending = 1;
    end
    tick();
    axi_arvalid_i = 1'b0;
  endtask

  task automatic drive_w();
    wexp_t e;
    bit ok;
    int n;
    while (wdrv.size() != 0) begin
      e = wdrv.pop_front();
      axi_wvalid_i = 1'b1;
      axi_wdata_i = e.d;
      axi_wstrb_i = e.s;
      ok = 0; n = 0;
      while (!ok && n < 200) begin
        @(negedge clk_i);
        ok = axi_wready_o;
        n++;
      end
      if (!ok) chk("w_timeout", 0, 1);
      tick();
    end
    axi_wvalid_i = 1'b0;
  endtask

  task automatic drive_b();
    bit ok;
    int n;
    repeat ($urandom_range(0, 2)) tick();
    axi_bready_i = 1'b1;
    ok = 0; n = 0;
    while (!ok && n < 200) begin
      @(negedge clk_i);
      ok = axi_bvalid_o;
      n++;
    end
    if (!ok) chk("b_timeout", 0, 1);
    tick();
    axi_bready_i = 1'b0;
  endtask

  task automatic wait_r();
    int n;
    n = 0;
    while (exp_r.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    if (exp_r.size() != 0) chk("r_timeout", exp_r.size(), 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] id,
      input logic [7:0] len, input logic [1:0] bt);
    plan_write(a, id, len, bt, 0, 32'd0, 4'd0);
    hs_aw(a, id, len, bt);
    drive_w();
    drive_b();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] id,
      input logic [7:0] len, input logic [1:0] bt);
    plan_read(a, id, len, bt);
    hs_ar(a, id, len, bt);
    wait_r();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [1:0] bt;
    logic [7:0] ln;
    logic [7:0] wl [4];
    wexp_t e;
    wl = '{8'd1, 8'd3, 8'd7, 8'd15};
    for (int i = 0; i < (1 << AW); i++) mdl[i] = 32'd0;
    rst_i = 1'b0;
    axi_awvalid_i = 0; axi_awaddr_i = 0; axi_awid_i = 0;
    axi_awlen_i = 0; axi_awburst_i = 0;
    axi_wvalid_i = 0; axi_wdata_i = 0; axi_wstrb_i = 0; axi_wlast_i = 0;
    axi_bready_i = 0;
    axi_arvalid_i = 0; axi_araddr_i = 0; axi_arid_i = 0;
    axi_arlen_i = 0; axi_arburst_i = 0;
    tick();
    clr = 0;
    repeat (2) tick();
    @(negedge clk_i);
    chk("reset_outputs", outv, 0);
    tick();
    rst_i = 1'b1;
    tick();

    // Tie out of reset: write first; then read beats a second write.
    plan_write(32'h40, 4'd3, 8'd0, 2'b01, 1, 32'h1122_3344, 4'hF);
    plan_read(32'h40, 4'd9, 8'd0, 2'b01);
    axi_awaddr_i = 32'h40; axi_awid_i = 4'd3;
    axi_awlen_i = 8'd0; axi_awburst_i = 2'b01;
    axi_araddr_i = 32'h40; axi_arid_i = 4'd9;
    axi_arlen_i = 8'd0; axi_arburst_i = 2'b01;
    axi_awvalid_i = 1'b1; axi_arvalid_i = 1'b1;
    @(negedge clk_i);
    chk("tie1_grant", {axi_awready_o, axi_arready_o}, 2'b10);
    tick();
    axi_awvalid_i = 1'b0;
    drive_w();
    plan_write(32'h40, 4'd4, 8'd0, 2'b01, 1, 32'h5566_7788, 4'hF);
    axi_awid_i = 4'd4;
    axi_awvalid_i = 1'b1;
    drive_b();
    @(negedge clk_i);
    chk("tie2_grant", {axi_awready_o, axi_arready_o}, 2'b01);
    ar_cyc = cyc;
    first_pending = 1;
    tick();
    axi_arvalid_i = 1'b0;
    wait_r();
    hs_aw(32'h40, 4'd4, 8'd0, 2'b01);
    drive_w();
    drive_b();
    do_read(32'h40, 4'd1, 8'd0, 2'b01);

    // Single write then read at 0x10.
    plan_write(32'h10, 4'd1, 8'd0, 2'b01, 1, 32'hDEAD_BEEF, 4'hF);
    hs_aw(32'h10, 4'd1, 8'd0, 2'b01);
    drive_w();
    drive_b();
    do_read(32'h10, 4'd2, 8'd0, 2'b01);

    // INCR 4-beat read with rready high.
    rmode = 0;
    do_write(32'h100, 4'd2, 8'd3, 2'b01);
    do_read(32'h100, 4'd5, 8'd3, 2'b01);

    // WRAP read from 0x38.
    do_write(32'h30, 4'd6, 8'd3, 2'b01);
    do_read(32'h38, 4'd6, 8'd3, 2'b10);

    // Partial byte strobes.
    plan_write(32'h200, 4'd7, 8'd0, 2'b01, 1, 32'hA5A5_A5A5, 4'h5);
    hs_aw(32'h200, 4'd7, 8'd0, 2'b01);
    drive_w();
    drive_b();
    do_read(32'h200, 4'd7, 8'd0, 2'b01);

    // 8-beat read under 1 0 0 1 rready pattern.
    do_write(32'h280, 4'd1, 8'd7, 2'b01);
    rmode = 2;
    do_read(32'h280, 4'd3, 8'd7, 2'b01);

    for (int t = 0; t < 30; t++) begin
      rmode = $urandom_range(0, 2);
      bt = 2'($urandom_range(0, 3));
      ln = (bt == 2'b10) ? wl[$urandom_range(0, 3)]
                         : 8'($urandom_range(0, 15));
      a = ($urandom & 32'hFFFF_0000)
        | (32'($urandom_range(0, 255)) << 2);
      if ($urandom_range(0, 1) == 1)
        do_write(a, 4'($urandom), ln, bt);
      else
        do_read(a, 4'($urandom), ln, bt);
    end

    // Reset during beat 2 of a 4-beat write.
    rmode = 0;
    hs_aw(32'h3000, 4'd1, 8'd3, 2'b01);
    e.a = widx(32'h3000);
    e.s = 4'hF;
    e.d = $urandom;
    exp_w.push_back(e);
    axi_wvalid_i = 1'b1;
    axi_wdata_i = e.d;
    axi_wstrb_i = e.s;
    @(negedge clk_i);
    chk("midburst_wready", axi_wready_o, 1);
    tick();
    axi_wdata_i = $urandom;
    rst_i = 1'b0;
    tick();
    @(negedge clk_i);
    chk("midburst_reset", outv, 0);
    tick();
    axi_wvalid_i = 1'b0;
    rst_i = 1'b1;
    exp_w.delete();
    exp_ra.delete();
    exp_r.delete();
    exp_b.delete();
    iss = 0; pops = 0; in_burst = 0; first_pending = 0;
    do_write(32'h500, 4'd8, 8'd1, 2'b01);
    do_read(32'h500, 4'd8, 8'd1, 2'b01);

    repeat (4) tick();
    chk("left_w", exp_w.size(), 0);
    chk("left_ra", exp_ra.size(), 0);
    chk("left_r", exp_r.size(), 0);
    chk("left_b", exp_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
